// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, reset PC,
// NOP word, AdEL exception code and the legal instruction-memory window.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] FETCH_NOP_INS  = 32'h0000_0000;
    localparam logic [4:0]  EXC_ADEL       = 5'd4;
    localparam logic [31:0] IMEM_LO        = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI        = 32'h0000_6FFF;

    // A fetch address is unusable if it is not word aligned or falls
    // outside the instruction-memory window.
    function automatic logic fetch_addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < IMEM_LO) || (addr > IMEM_HI);
    endfunction

endpackage

// File: rtl/fetch_addr_chk.sv
// Combinational alignment and range check applied to every fetch address
// before it is allowed onto the instruction-memory request port.
module fetch_addr_chk
    import fetch_pkg::*;
(
    input  logic [31:0] addr,
    output logic        bad
);

    assign bad = fetch_addr_bad(addr);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus F/D pipeline register of the five-stage MIPS
// pipeline. Keeps the fetch PC, runs a single-outstanding request/valid
// handshake to instruction memory, absorbs a response that arrives during a
// D stall in a one-entry hold buffer, and raises F_wait while no instruction
// is ready.
// Optional feature: define FETCH_EXC_EN to check every fetch address and turn
// bad addresses into an AdEL-tagged NOP (adds D_ExcValid / D_ExcCode ports).
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter logic [31:0] NOP_INS  = FETCH_NOP_INS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        D_Flush,
    input  logic [31:0] NPC,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC,
    output logic [31:0] D_Ins,
    output logic        F_wait,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata
`ifdef FETCH_EXC_EN
    ,
    output logic        D_ExcValid,
    output logic [4:0]  D_ExcCode
`endif
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0] f_pc_p0;
    logic [31:0] d_pc_p1;
    logic [31:0] d_ins_p1;
    logic [31:0] hold_buf;

    logic        req_want;
    logic [31:0] req_addr;
    logic        xfer;
    logic        capture;
    logic [31:0] xfer_word;
    logic        rsp_vld;
    logic [31:0] rsp_word;
    logic        f_wait;

`ifdef FETCH_EXC_EN
    logic        addr_bad;
    logic        fault_p0;
    logic        hold_exc_p1;
    logic        d_exc_vld_p1;
    logic        xfer_exc;

    fetch_addr_chk u_addr_chk (
        .addr (req_addr),
        .bad  (addr_bad)
    );

    // A faulting fetch is never sent to memory; the WAIT state completes it
    // on its own with a NOP word instead.
    assign rsp_vld  = imem_rvalid | fault_p0;
    assign rsp_word = fault_p0 ? NOP_INS : imem_rdata;
    assign imem_req = req_want & ~addr_bad;
`else
    assign rsp_vld  = imem_rvalid;
    assign rsp_word = imem_rdata;
    assign imem_req = req_want;
`endif

    assign imem_addr = req_addr;
    assign F_PC      = f_pc_p0;
    assign D_PC      = d_pc_p1;
    assign D_Ins     = d_ins_p1;
    assign F_wait    = f_wait;

    // FSM state register; reset returns to IDLE so the first request goes
    // out in the first cycle after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, transfer/capture decisions and request generation.
    always_comb begin
        state_d   = state_q;
        req_want  = 1'b0;
        req_addr  = f_pc_p0;
        xfer      = 1'b0;
        capture   = 1'b0;
        xfer_word = hold_buf;
        f_wait    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset) begin
                    req_want = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (rsp_vld) begin
                    if (stall) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end else begin
                        xfer      = 1'b1;
                        xfer_word = rsp_word;
                    end
                end else begin
                    f_wait = 1'b1;
                end
            end
            HOLD: begin
                if (!stall) begin
                    xfer    = 1'b1;
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Every transfer immediately requests the next PC from decode so a
        // one-cycle memory sustains one instruction per cycle.
        if (xfer) begin
            req_want = 1'b1;
            req_addr = NPC;
        end
    end

    // Fetch PC and F/D register advance together on a transfer; a flush
    // annuls only the instruction word, the slot keeps its own PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_pc_p0  <= RESET_PC;
            d_pc_p1  <= 32'h0;
            d_ins_p1 <= 32'h0;
        end else if (xfer) begin
            f_pc_p0  <= NPC;
            d_pc_p1  <= f_pc_p0;
            d_ins_p1 <= D_Flush ? NOP_INS : xfer_word;
        end
    end

    // Hold buffer parks a response that arrived while D was stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_buf <= 32'h0;
        end else if (capture) begin
            hold_buf <= rsp_word;
        end
    end

`ifdef FETCH_EXC_EN
    // Exception tag of whichever word is being transferred.
    always_comb begin
        xfer_exc = (state_q == HOLD) ? hold_exc_p1 : fault_p0;
    end

    // Fault tracking for the outstanding fetch, its held copy and the F/D tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_p0     <= 1'b0;
            hold_exc_p1  <= 1'b0;
            d_exc_vld_p1 <= 1'b0;
        end else begin
            if (req_want) begin
                fault_p0 <= addr_bad;
            end
            if (capture) begin
                hold_exc_p1 <= fault_p0;
            end
            if (xfer) begin
                d_exc_vld_p1 <= xfer_exc & ~D_Flush;
            end
        end
    end

    assign D_ExcValid = d_exc_vld_p1;
    assign D_ExcCode  = d_exc_vld_p1 ? EXC_ADEL : 5'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a cycle driver runs a latency-programmable
// instruction memory and a transaction-level fetch model that pushes expected
// requests and F/D contents into queues; two monitors pop and compare.
`timescale 1ns/1ps
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        D_Flush;
    logic [31:0] NPC;
    logic [31:0] F_PC;
    logic [31:0] D_PC;
    logic [31:0] D_Ins;
    logic        F_wait;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
`ifdef FETCH_EXC_EN
    logic        D_ExcValid;
    logic [4:0]  D_ExcCode;
`endif

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .D_Flush     (D_Flush),
        .NPC         (NPC),
        .F_PC        (F_PC),
        .D_PC        (D_PC),
        .D_Ins       (D_Ins),
        .F_wait      (F_wait),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata)
`ifdef FETCH_EXC_EN
        ,
        .D_ExcValid  (D_ExcValid),
        .D_ExcCode   (D_ExcCode)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          req;
        logic [31:0] addr;
        bit          fwait;
        logic [31:0] fpc;
    } cyc_rec_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] ins;
        bit          exc;
    } fd_rec_t;

    cyc_rec_t cyc_q[$];
    fd_rec_t  fd_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // memory model state
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat_fixed;

    // fetch reference model state
    bit          m_first;
    bit          m_out;
    bit          m_bad;
    bit          m_have;
    bit          m_hexc;
    logic [31:0] m_fpc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {16'h3c01, a[15:0] ^ 16'h2234};
    endfunction

    function automatic bit is_bad(input logic [31:0] a);
`ifdef FETCH_EXC_EN
        return (a[1:0] != 2'b00) || (a < 32'h3000) || (a > 32'h6fff);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] seq_npc(input logic [31:0] pc);
        logic [31:0] n;
        n = {pc[31:2], 2'b00} + 32'd4;
        if (n < 32'h3000 || n > 32'h6ffc) n = 32'h3000;
        return n;
    endfunction

    function automatic logic [31:0] pick_npc(input logic [31:0] pc);
        int r;
        logic [31:0] n;
        r = $urandom_range(0, 99);
        if (r < 75) n = seq_npc(pc);
        else        n = 32'h3000 + 32'($urandom_range(0, 4095)) * 32'd4;
`ifdef FETCH_EXC_EN
        if (r >= 95) n = (r[0]) ? 32'h3000 + 32'($urandom_range(0, 63)) : 32'h7000;
`endif
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, run memory, advance the reference model.
    task automatic step(input bit st, input bit fl, input logic [31:0] np);
        bit          avail;
        bit          ex;
        logic [31:0] word;
        cyc_rec_t    cr;
        fd_rec_t     fr;
        @(negedge clk);
        cyc++;
        stall       = st;
        D_Flush     = fl;
        NPC         = np;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(mem_addr);
                mem_busy    = 1'b0;
            end
        end
        #1;
        if (imem_req) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 3);
        end
        cr.cyc   = cyc;
        cr.req   = 1'b0;
        cr.addr  = 32'h0;
        cr.fwait = 1'b0;
        cr.fpc   = m_fpc;
        if (m_first) begin
            m_first = 1'b0;
            m_out   = 1'b1;
            m_bad   = is_bad(m_fpc);
            cr.req  = !m_bad;
            cr.addr = m_fpc;
        end else begin
            avail    = m_have || (m_out && (imem_rvalid || m_bad));
            ex       = m_have ? m_hexc : m_bad;
            word     = ex ? FETCH_NOP_INS : memf(m_fpc);
            cr.fwait = m_out && !imem_rvalid && !m_bad;
            if (avail && !st) begin
                fr.cyc = cyc;
                fr.pc  = m_fpc;
                fr.ins = fl ? FETCH_NOP_INS : word;
                fr.exc = ex && !fl;
                fd_q.push_back(fr);
                m_fpc   = np;
                m_have  = 1'b0;
                m_out   = 1'b1;
                m_bad   = is_bad(np);
                cr.req  = !m_bad;
                cr.addr = np;
            end else if (avail) begin
                m_have = 1'b1;
                m_hexc = ex;
                m_out  = 1'b0;
                m_bad  = 1'b0;
            end
        end
        cyc_q.push_back(cr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_F_PC", F_PC, FETCH_RESET_PC);
        chk("rst_D_PC", D_PC, 32'h0);
        chk("rst_D_Ins", D_Ins, 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_F_wait", 32'(F_wait), 32'h0);
`ifdef FETCH_EXC_EN
        chk("rst_D_ExcValid", 32'(D_ExcValid), 32'h0);
        chk("rst_D_ExcCode", 32'(D_ExcCode), 32'h0);
`endif
        cyc_q.delete();
        fd_q.delete();
        mem_busy    = 1'b0;
        imem_rvalid = 1'b0;
        m_first     = 1'b1;
        m_out       = 1'b0;
        m_bad       = 1'b0;
        m_have      = 1'b0;
        m_hexc      = 1'b0;
        m_fpc       = FETCH_RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Request-side monitor: per-cycle request, address, F_wait and F_PC.
    initial begin
        cyc_rec_t r;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && cyc_q.size() > 0 && cyc_q[0].cyc == cyc) begin
                r = cyc_q.pop_front();
                chk("imem_req", 32'(imem_req), 32'(r.req));
                if (r.req) chk("imem_addr", imem_addr, r.addr);
                chk("F_wait", 32'(F_wait), 32'(r.fwait));
                chk("F_PC", F_PC, r.fpc);
            end
        end
    end

    // F/D monitor: D_PC/D_Ins follow the transfer queue, otherwise hold.
    initial begin
        fd_rec_t     r;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        bit          e_exc;
        e_pc  = 32'h0;
        e_ins = 32'h0;
        e_exc = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                e_pc  = 32'h0;
                e_ins = 32'h0;
                e_exc = 1'b0;
            end else begin
                if (fd_q.size() > 0 && fd_q[0].cyc == cyc) begin
                    r     = fd_q.pop_front();
                    e_pc  = r.pc;
                    e_ins = r.ins;
                    e_exc = r.exc;
                end
                chk("D_PC", D_PC, e_pc);
                chk("D_Ins", D_Ins, e_ins);
`ifdef FETCH_EXC_EN
                chk("D_ExcValid", 32'(D_ExcValid), 32'(e_exc));
                chk("D_ExcCode", 32'(D_ExcCode), e_exc ? 32'd4 : 32'd0);
`endif
            end
        end
    end

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        D_Flush     = 1'b0;
        NPC         = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        lat_fixed   = 1;
        do_reset();

        // single-cycle memory, sequential fetch
        lat_fixed = 1;
        repeat (8) step(1'b0, 1'b0, seq_npc(m_fpc));

        // three-cycle memory
        lat_fixed = 3;
        repeat (12) step(1'b0, 1'b0, seq_npc(m_fpc));

        // stall across a response arrival
        lat_fixed = 2;
        repeat (3) step(1'b0, 1'b0, seq_npc(m_fpc));
        repeat (4) step(1'b1, 1'b0, seq_npc(m_fpc));
        repeat (4) step(1'b0, 1'b0, seq_npc(m_fpc));

        // likely-branch flush redirecting to 0x3010
        lat_fixed = 1;
        step(1'b0, 1'b0, seq_npc(m_fpc));
        step(1'b0, 1'b1, 32'h3010);
        repeat (3) step(1'b0, 1'b0, seq_npc(m_fpc));

        // stall and flush together, flush lands on the first free edge
        repeat (2) step(1'b1, 1'b1, 32'h3020);
        step(1'b0, 1'b1, 32'h3020);
        repeat (3) step(1'b0, 1'b0, seq_npc(m_fpc));

`ifdef FETCH_EXC_EN
        // misaligned fetch address
        step(1'b0, 1'b0, 32'h3002);
        step(1'b0, 1'b0, 32'h3008);
        repeat (3) step(1'b0, 1'b0, seq_npc(m_fpc));
`endif

        // randomized traffic
        lat_fixed = 0;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15, pick_npc(m_fpc));
        end

        // reset while a slow fetch is outstanding
        lat_fixed = 3;
        repeat (5) step(1'b0, 1'b0, seq_npc(m_fpc));
        do_reset();
        lat_fixed = 1;
        repeat (6) step(1'b0, 1'b0, seq_npc(m_fpc));

        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
